// File: rtl/menu_char_rom_arbiter_if.sv
// rtl/menu_char_rom_arbiter_if.sv - requester-side bundle of the menu char ROM arbiter
interface menu_char_rom_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 8,
   parameter int CODE_W = 7
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [CODE_W-1:0]       rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/menu_char_rom_arbiter.sv
// rtl/menu_char_rom_arbiter.sv - round-robin share of one menu char ROM among N_REQ requesters
// Defining MENU_ARB_LOCK_EN adds the lock input and burst-hold grants of up to MAX_BURST clks.
module menu_char_rom_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 8,
   parameter int CODE_W    = 7,
   parameter int ROM_LAT   = 1,
   parameter int MAX_BURST = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   menu_char_rom_arbiter_if.slave bus,
`ifdef MENU_ARB_LOCK_EN
   input  logic [N_REQ-1:0]     lock,
`endif
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [CODE_W-1:0]    rom_code
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || ROM_LAT < 1 || ROM_LAT > 3 || MAX_BURST < 1) begin : g_bad_param
      $error("menu_char_rom_arbiter: parameter out of range");
   end

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] base;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] gnt_idx;
   logic             gnt_any;
   logic [N_REQ-1:0] gnt_c;
   logic [N_REQ-1:0] pipe [ROM_LAT];

   function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] v);
      return (v == PTR_W'(N_REQ - 1)) ? '0 : v + 1'b1;
   endfunction

`ifdef MENU_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   logic             lock_active;
   logic [PTR_W-1:0] owner;
   logic [CNT_W-1:0] burst_cnt;
   logic             hold;

   assign hold = lock_active && bus.req[owner] && lock[owner];
   // A lock that just fell through resumes the scan right after its owner.
   assign base = lock_active ? inc_mod(owner) : ptr;
`else
   assign base = ptr;
`endif

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      sum     = '0;
`ifdef MENU_ARB_LOCK_EN
      if (hold) begin
         gnt_any = 1'b1;
         gnt_idx = owner;
      end
`endif
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, base} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N_REQ))
            sum = sum - (PTR_W+1)'(N_REQ);
         if (!gnt_any && bus.req[sum[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = sum[PTR_W-1:0];
         end
      end
      if (rst)
         gnt_any = 1'b0;
   end

   always_comb begin
      gnt_c    = '0;
      rom_addr = '0;
      if (gnt_any) begin
         gnt_c[gnt_idx] = 1'b1;
         rom_addr       = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
      end
   end

   assign bus.gnt    = gnt_c;
   assign bus.rvalid = pipe[ROM_LAT-1];
   assign bus.rdata  = rom_code;

   // Grant one-hot travels alongside the ROM read so the response finds its owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < ROM_LAT; s++)
            pipe[s] <= '0;
      end else begin
         pipe[0] <= gnt_c;
         for (int s = 1; s < ROM_LAT; s++)
            pipe[s] <= pipe[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
`ifdef MENU_ARB_LOCK_EN
         lock_active <= 1'b0;
         owner       <= '0;
         burst_cnt   <= '0;
`endif
      end else begin
`ifdef MENU_ARB_LOCK_EN
         if (hold) begin
            if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
               lock_active <= 1'b0;
               burst_cnt   <= '0;
               ptr         <= inc_mod(owner);
            end else begin
               burst_cnt <= burst_cnt + 1'b1;
            end
         end else if (gnt_any && lock[gnt_idx]) begin
            if (MAX_BURST == 1) begin
               lock_active <= 1'b0;
               burst_cnt   <= '0;
               ptr         <= inc_mod(gnt_idx);
            end else begin
               lock_active <= 1'b1;
               owner       <= gnt_idx;
               burst_cnt   <= CNT_W'(1);
            end
         end else begin
            lock_active <= 1'b0;
            burst_cnt   <= '0;
            if (gnt_any)
               ptr <= inc_mod(gnt_idx);
            else if (lock_active)
               ptr <= inc_mod(owner);
         end
`else
         if (gnt_any)
            ptr <= inc_mod(gnt_idx);
`endif
      end
   end
endmodule

// File: tb/tb_menu_char_rom_arbiter.sv
// tb/tb_menu_char_rom_arbiter.sv - directed bench for menu_char_rom_arbiter with ROM_LAT = 2
module tb_menu_char_rom_arbiter;
   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int CW  = 7;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rom_addr;
   logic [CW-1:0] rom_code;
   logic [AW-1:0] rom_pipe [LAT];
`ifdef MENU_ARB_LOCK_EN
   logic [N-1:0]  lock;
`endif
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   menu_char_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .CODE_W(CW)) bus ();

   menu_char_rom_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .CODE_W(CW), .ROM_LAT(LAT), .MAX_BURST(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
`ifdef MENU_ARB_LOCK_EN
      .lock     (lock),
`endif
      .rom_addr (rom_addr),
      .rom_code (rom_code)
   );

   // ROM stand-in: code = addr[6:0] + 0x42, so 8'h04 reads back 'F'.
   always @(posedge clk) begin
      rom_pipe[0] <= rom_addr;
      for (int s = 1; s < LAT; s++)
         rom_pipe[s] <= rom_pipe[s-1];
   end
   assign rom_code = rom_pipe[LAT-1][6:0] + 7'h42;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.req = '0;
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'hF;
      bus.addr = {8'h3B, 8'h32, 8'h21, 8'h10};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         total++;
         if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
         total++;
         if (bus.rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid: got %b want 0000", bus.rvalid); end
         total++;
         if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); end
      total++;
      if (rom_addr !== 8'h10) begin bad++; $display("FAIL reset_first_addr: got %h want 10", rom_addr); end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_single();
      bus.req = 4'b0100;
      bus.addr[16 +: 8] = 8'h04;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt c%0d: got %b want 0100", c, bus.gnt); end
         total++;
         if (rom_addr !== 8'h04) begin bad++; $display("FAIL single_addr c%0d: got %h want 04", c, rom_addr); end
         total++;
         if (c < LAT) begin
            if (bus.rvalid !== 4'b0000) begin bad++; $display("FAIL single_rvalid c%0d: got %b want 0000", c, bus.rvalid); end
         end else begin
            if (bus.rvalid !== 4'b0100 || bus.rdata !== 7'h46)
               begin bad++; $display("FAIL single_resp c%0d: got %b/%h want 0100/46", c, bus.rvalid, bus.rdata); end
         end
      end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_all();
      logic [7:0] addrs [4];
      logic [6:0] codes [4];
      addrs = '{8'h10, 8'h21, 8'h32, 8'h3B};
      codes = '{7'h52, 7'h63, 7'h74, 7'h7D};
      apply_reset();
      bus.addr = {8'h3B, 8'h32, 8'h21, 8'h10};
      bus.req = 4'hF;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (bus.gnt !== (4'b0001 << (c % 4)) || rom_addr !== addrs[c % 4])
            begin bad++; $display("FAIL all_gnt c%0d: got %b/%h want %b/%h", c, bus.gnt, rom_addr, 4'b0001 << (c % 4), addrs[c % 4]); end
         total++;
         if (c < LAT) begin
            if (bus.rvalid !== 4'b0000) begin bad++; $display("FAIL all_rvalid c%0d: got %b want 0000", c, bus.rvalid); end
         end else begin
            if (bus.rvalid !== (4'b0001 << ((c - LAT) % 4)) || bus.rdata !== codes[(c - LAT) % 4])
               begin bad++; $display("FAIL all_resp c%0d: got %b/%h want %b/%h", c, bus.rvalid, bus.rdata,
                                     4'b0001 << ((c - LAT) % 4), codes[(c - LAT) % 4]); end
         end
      end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.req = 4'b0100;
      #1;
      total++;
      if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL wrap_setup: got %b want 0100", bus.gnt); end
      @(negedge clk); bus.req = 4'b0011; #1;
      total++;
      if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL wrap_first: got %b want 0001", bus.gnt); end
      @(negedge clk); #1;
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL wrap_second: got %b want 0010", bus.gnt); end
      @(negedge clk); #1;
      total++;
      if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL wrap_third: got %b want 0001", bus.gnt); end
      @(negedge clk); bus.req = 4'b0000; #1;
      total++;
      if (bus.gnt !== 4'b0000 || rom_addr !== 8'h00)
         begin bad++; $display("FAIL wrap_idle: got %b/%h want 0000/00", bus.gnt, rom_addr); end
      @(negedge clk); bus.req = 4'b0011; #1;
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL wrap_after_idle: got %b want 0010", bus.gnt); end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_midflight();
      apply_reset();
      bus.req = 4'b0010;
      #1;
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt1: got %b want 0010", bus.gnt); end
      @(negedge clk); rst = 1'b1; bus.req = 4'hF; #1;
      total++;
      if (bus.gnt !== 4'b0000 || bus.rvalid !== 4'b0000)
         begin bad++; $display("FAIL mid_in_reset: got %b/%b want 0000/0000", bus.gnt, bus.rvalid); end
      @(negedge clk); rst = 1'b0; #1;
      total++;
      if (bus.gnt !== 4'b0001 || bus.rvalid !== 4'b0000)
         begin bad++; $display("FAIL mid_after_reset: got %b/%b want 0001/0000", bus.gnt, bus.rvalid); end
      @(negedge clk); bus.req = 4'b0000; #1;
      total++;
      if (bus.rvalid !== 4'b0000) begin bad++; $display("FAIL mid_no_stale: got %b want 0000", bus.rvalid); end
      @(negedge clk); #1;
      total++;
      if (bus.rvalid !== 4'b0001 || bus.rdata !== 7'h52)
         begin bad++; $display("FAIL mid_first_resp: got %b/%h want 0001/52", bus.rvalid, bus.rdata); end
      idle(3);
   endtask

   task automatic test_lock();
      logic [3:0] want;
      apply_reset();
      bus.req = 4'b0011;
`ifdef MENU_ARB_LOCK_EN
      lock = 4'b0001;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         want = (c == 16) ? 4'b0010 : 4'b0001;
         total++;
         if (bus.gnt !== want) begin bad++; $display("FAIL lock_gnt c%0d: got %b want %b", c, bus.gnt, want); end
      end
      @(negedge clk);
      lock = 4'b0000;
`else
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         want = (c % 2 == 0) ? 4'b0001 : 4'b0010;
         total++;
         if (bus.gnt !== want) begin bad++; $display("FAIL nolock_gnt c%0d: got %b want %b", c, bus.gnt, want); end
      end
      @(negedge clk);
`endif
      idle(3);
   endtask

   initial begin
`ifdef MENU_ARB_LOCK_EN
      lock = 4'b0000;
`endif
      test_reset();
      test_single();
      test_all();
      test_wrap();
      test_midflight();
      test_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
